esc_pwm_interface: RTL and testbench

- Converts an 11-bit speed command from the flight controller into one PWM pulse for a motor ESC.
- Each write produces a single high pulse whose width grows linearly with SPEED:
  - minimum width 6250 clocks (125 us at 50 MHz, ESC idle);
  - maximum width 12391 clocks.
- Sits between the flight controller's per-motor speed outputs and the ESC pin; one instance per motor.
- The flight controller issues wrt at the frame rate; this block only shapes the pulse.

---
 rtl/esc_pwm_interface.sv | 39 +++
 tb/tb_esc_pwm_interface.sv | 134 +++++++++++++
 2 files changed

// File: rtl/esc_pwm_interface.sv
// Single-shot ESC pulse generator: each wrt strobe starts one PWM high pulse
// lasting MIN_CLKS + SCALE*SPEED clock periods.
module esc_pwm_interface #(
  parameter int MIN_CLKS = 6250,
  parameter int SCALE    = 3,
  parameter int CNT_W    = 14
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wrt,
  input  logic [10:0] SPEED,
  output logic        PWM
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] width_n;

  // The counter is the captured form of SPEED, so later SPEED changes
  // without wrt cannot alter a pulse already in flight.
  always_comb begin
    width_n = CNT_W'(MIN_CLKS) + CNT_W'(SCALE) * CNT_W'(SPEED);
  end

  // PWM drops on the edge where the count reaches zero, giving exactly
  // width_n high periods measured from the wrt edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      PWM <= 1'b0;
    end else if (wrt) begin
      cnt <= width_n;
      PWM <= 1'b1;
    end else if (PWM) begin
      cnt <= cnt - 1'b1;
      PWM <= (cnt != CNT_W'(1));
    end
  end

endmodule

// File: tb/tb_esc_pwm_interface.sv
// Directed bench for esc_pwm_interface: pulse widths, retrigger, async reset,
// SPEED changes without wrt and held wrt.
module tb_esc_pwm_interface;

  logic        clk;
  logic        rst_n;
  logic        wrt;
  logic [10:0] SPEED;
  logic        PWM;

  int unsigned n_tests;
  int unsigned n_fail;
  int unsigned hi;
  int unsigned cnt;

  esc_pwm_interface dut (
    .clk   (clk),
    .rst_n (rst_n),
    .wrt   (wrt),
    .SPEED (SPEED),
    .PWM   (PWM)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Called at a negedge; the following posedge is the wrt edge E0,
  // and the task returns at the negedge just after E0.
  task automatic pulse_wrt(input logic [10:0] s);
    SPEED = s;
    wrt   = 1'b1;
    @(negedge clk);
    wrt   = 1'b0;
  endtask

  // Counts negedges with PWM high, starting at the current one.
  task automatic measure_high(output int unsigned h);
    h = 0;
    while (PWM === 1'b1 && h < 20000) begin
      h++;
      @(negedge clk);
    end
  endtask

  // Counts negedges with PWM high over a fixed window.
  task automatic count_high(input int unsigned cycles, output int unsigned h);
    h = 0;
    for (int i = 0; i < cycles; i++) begin
      if (PWM !== 1'b0) h++;
      @(negedge clk);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    wrt     = 1'b0;
    SPEED   = '0;
    repeat (3) @(negedge clk);
    check("reset_pwm", PWM, 1'b0);
    rst_n = 1'b1;
    count_high(20, cnt);
    check("idle_after_reset", cnt, 0);

    pulse_wrt(11'h000);
    measure_high(hi);
    check("width_speed0", hi, 6250);
    check("low_after_speed0", PWM, 1'b0);

    pulse_wrt(11'h228);
    measure_high(hi);
    check("width_speed552", hi, 7906);

    pulse_wrt(11'h7FF);
    measure_high(hi);
    check("width_speed2047", hi, 12391);
    count_high(50, cnt);
    check("idle_between_pulses", cnt, 0);

    // Retrigger at E0+3000 with SPEED=100 -> high until E0+3000+6550.
    pulse_wrt(11'd0);
    cnt = 0;
    for (int i = 0; i < 2999; i++) begin
      if (PWM !== 1'b1) cnt++;
      @(negedge clk);
    end
    pulse_wrt(11'd100);
    measure_high(hi);
    check("retrigger_no_glitch", cnt, 0);
    check("retrigger_total", hi + 3000, 9550);

    // Asynchronous reset mid-pulse.
    pulse_wrt(11'd552);
    repeat (4000) @(negedge clk);
    check("pulse_active_pre_reset", PWM, 1'b1);
    rst_n = 1'b0;
    #1;
    check("async_reset_pwm", PWM, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    count_high(100, cnt);
    check("low_after_reset", cnt, 0);
    pulse_wrt(11'd1);
    measure_high(hi);
    check("width_after_reset", hi, 6253);

    // SPEED change without wrt has no effect.
    pulse_wrt(11'd0);
    SPEED = 11'h7FF;
    measure_high(hi);
    check("speed_change_ignored", hi, 6250);

    // wrt held for three edges: pulse ends N clocks after the last one.
    SPEED = 11'd5;
    wrt   = 1'b1;
    repeat (3) @(negedge clk);
    wrt   = 1'b0;
    measure_high(hi);
    check("held_wrt_width", hi, 6265);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
